// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch and load/store.
// Each access runs issue -> wait MEM_LAT -> respond; ties in IDLE alternate round-robin.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t     state;
  logic       grant;
  logic       last_grant;
  logic       is_store;
  logic [3:0] cnt;
  logic       pick_ls;

  // On a tie the requester that was not served last wins
  always_comb begin
    pick_ls = 1'b0;
    if (ls_req && if_req) begin
      pick_ls = ~last_grant;
    end else if (ls_req) begin
      pick_ls = 1'b1;
    end else begin
      pick_ls = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      is_store   <= 1'b0;
      cnt        <= 4'd0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      if_ack     <= 1'b0;
      ls_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            grant    <= pick_ls;
            is_store <= pick_ls & ls_we;
            mem_en   <= 1'b1;
            mem_we   <= pick_ls & ls_we;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // Stores complete without touching ls_rdata
            if (!grant) begin
              if_rdata <= mem_rdata;
            end else if (!is_store) begin
              ls_rdata <= mem_rdata;
            end
            if_ack <= ~grant;
            ls_ack <= grant;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // grant only changes on leaving IDLE, so the select holds its last value while idle
  assign mem_sel   = grant;
  assign mem_addr  = mem_sel ? ls_addr : if_addr;
  assign mem_wdata = ls_wdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between instruction fetch (IF) and load/store (LS).
- Owns the select of a 32-bit 2:1 address multiplexer (multiplexer21) in front of the memory: a = LS address, b = IF address.
- Sequences each access as issue → wait MEM_LAT → respond, and returns a one-cycle ack to the granted requester.
- Sits between the IF/MEM pipeline stages and the memory block; stalls are produced by the requesters holding req until ack.

Parameters:
- DATA_W, 32, address/data width.
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  IF read request; held until if_ack.
- if_addr  input  DATA_W  IF address; stable while if_req is high.
- if_ack  output  1  one-cycle completion pulse to IF.
- if_rdata  output  DATA_W  registered read data for IF.
- ls_req  input  1  LS request; held until ls_ack.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  DATA_W  LS address; stable while ls_req is high.
- ls_wdata  input  DATA_W  store data.
- ls_ack  output  1  one-cycle completion pulse to LS.
- ls_rdata  output  DATA_W  registered load data.
- mem_sel  output  1  address mux select; 1 = LS, 0 = IF.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  DATA_W  multiplexer21 output (a = ls_addr, b = if_addr, select = mem_sel).
- mem_wdata  output  DATA_W  equals ls_wdata.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high when state ≠ IDLE.

Behaviour:

Reset:
- rst is synchronous: state ← IDLE, grant ← 0, last_grant ← 0 (IF), wait counter ← 0.
- if_rdata and ls_rdata ← 0.
- if_ack, ls_ack, mem_en, mem_we, busy, mem_sel are all 0 from the cycle after rst.

State machine (IDLE, ISSUE, WAIT, RESP):
- **IDLE**
  - Only one of if_req/ls_req high: grant that requester, go to ISSUE.
  - Both high: grant the requester that is not last_grant (round-robin). After reset, the first tie goes to LS.
  - Neither high: stay in IDLE.
- **ISSUE** (exactly one cycle)
  - mem_en = 1.
  - mem_we = 1 only if grant = LS and ls_we = 1.
  - Load counter with MEM_LAT-1, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0: capture mem_rdata into the granted port's rdata register (loads and IF reads only; stores leave ls_rdata unchanged), then go to RESP.
  - With MEM_LAT = 1, WAIT lasts exactly one cycle.
- **RESP** (one cycle)
  - Assert the granted port's ack.
  - Set last_grant ← grant.
  - Go to IDLE.

Latency:
- Request sampled in IDLE at cycle T0 → mem_en at T0+1 → ack at T0+MEM_LAT+2.
- With MEM_LAT = 1, ack is at T0+3, so an idle-to-idle transaction takes 4 cycles.
- A new grant can be made in the IDLE cycle immediately after RESP.

Handshake and output timing:
- Requesters drop req at the edge that ends the ack cycle, so no re-grant occurs.
- A req dropped before ack is not aborted: the access completes and ack still pulses.
- mem_sel = grant from ISSUE through RESP, and holds its last value in IDLE.
- mem_en, mem_we and the acks are Moore outputs of the state register.
- if_ack and ls_ack are never high in the same cycle.

Reset mid-operation:
- rst high during ISSUE: that cycle's memory access (including a write) still occurs. The transaction is then abandoned with no ack.
- rst high during WAIT/RESP: the pending ack is suppressed and no rdata is updated.

Test Plan:
- MEM_LAT=1, if_req=1, if_addr=0x40, memory returns 0xDEADBEEF → mem_en at T0+1, mem_sel=0, if_ack at T0+3, if_rdata=0xDEADBEEF, ls_ack stays 0.
- After reset, if_req and ls_req rise in the same cycle (ls_addr=0x100, load) → LS served first (mem_sel=1, mem_addr=0x100, ls_ack at T0+3), then IF granted in the next IDLE (if_ack at T0+7).
- Both requesters continuously re-request for 4 transactions → grants alternate LS, IF, LS, IF; no two acks closer than 4 cycles.
- Store ls_we=1, ls_addr=0x20, ls_wdata=0x12345678, then load 0x20 → mem_we=1 for exactly one cycle; the load returns 0x12345678; ls_rdata is unchanged across the store.
- MEM_LAT=3, IF read → ack at T0+5; busy high for exactly 5 cycles.
- MEM_LAT=3, rst asserted in the second WAIT cycle → no ack, state IDLE and all outputs 0 next cycle, if_rdata=0; the next request completes normally.
